// File: rtl/erm16_bus_pkg.sv
// Shared bus definitions for the ERM16 datapath: arbiter FSM encoding and
// the default address/data widths used by control_unit, memory and arbiter.
package erm16_bus_pkg;

    localparam int ERM_AW = 16;
    localparam int ERM_DW = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational winner selection: round-robin starting after i_ptr, or fixed
// priority (lowest index wins) when PRIO_FIXED is set.
module rr_picker #(
    parameter int NREQ       = 3,
    parameter int IW         = 2,
    parameter int PRIO_FIXED = 0
) (
    input  logic [NREQ-1:0] i_eligible,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_found
);

    int          w_cand;
    logic [IW-1:0] w_cand_idx;

    always_comb begin
        o_found    = 1'b0;
        o_idx      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        // Candidate order: ptr+1, ptr+2, ... wrapping; or plain 0..NREQ-1.
        for (int k = 0; k < NREQ; k++) begin
            w_cand     = (PRIO_FIXED != 0) ? k : ((int'(i_ptr) + 1 + k) % NREQ);
            w_cand_idx = IW'(w_cand);
            if (!o_found && i_eligible[w_cand_idx]) begin
                o_found = 1'b1;
                o_idx   = w_cand_idx;
            end
        end
        o_onehot = o_found ? (NREQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single synchronous data-memory port between NREQ requesters
// using a level req / one-cycle ack handshake and a three-state access FSM.
module mem_bus_arbiter
    import erm16_bus_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int AW         = ERM_AW,
    parameter int DW         = ERM_DW,
    parameter int PRIO_FIXED = 0
) (
    input  logic             clk,
    input  logic             init,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_we,
    input  logic [DW-1:0]      mem_rdata,
    output logic               busy,
    output arb_state_t         dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_ack;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_win;
    logic [DW-1:0]   r_rdata;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_mem_we;

    logic [NREQ-1:0] w_eligible;
    logic [NREQ-1:0] w_onehot;
    logic [IW-1:0]   w_idx;
    logic            w_found;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_sel_we;

    // A requester being acked this cycle must not immediately win again.
    assign w_eligible = req & ~r_ack;

    rr_picker #(
        .NREQ       (NREQ),
        .IW         (IW),
        .PRIO_FIXED (PRIO_FIXED)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_onehot   (w_onehot),
        .o_idx      (w_idx),
        .o_found    (w_found)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IW'(i)) begin
                w_sel_addr  = addr[i*AW +: AW];
                w_sel_wdata = wdata[i*DW +: DW];
                w_sel_we    = we[i];
            end
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state     <= ARB_IDLE;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_ptr       <= IW'(NREQ - 1);
            r_win       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_we    <= w_sel_we;
                        r_gnt       <= w_onehot;
                        r_win       <= w_idx;
                        r_state     <= ARB_ADDR;
                    end else begin
                        r_mem_we <= 1'b0;
                    end
                end
                ARB_ADDR: begin
                    r_mem_we <= 1'b0;
                    r_state  <= ARB_DATA;
                end
                ARB_DATA: begin
                    // Writes load rdata too; the requester ignores it.
                    r_rdata <= mem_rdata;
                    r_ack   <= r_gnt;
                    r_gnt   <= '0;
                    r_ptr   <= r_win;
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign busy      = (r_state != ARB_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance with a synchronous memory
// model and a fixed-priority instance with a combinational address-derived memory.
module tb_mem_bus_arbiter;
    import erm16_bus_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;

    // clock / reset
    logic clk  = 1'b0;
    logic init = 1'b0;
    always #5 clk = ~clk;

    // round-robin instance
    logic [NREQ-1:0]    req   = '0;
    logic [NREQ-1:0]    we    = '0;
    logic [NREQ*AW-1:0] addr  = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]    gnt, ack;
    logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]      mem_addr;
    logic               mem_we, busy;
    arb_state_t         dbg_state;

    // fixed-priority instance
    logic [NREQ-1:0]    fx_req   = '0;
    logic [NREQ-1:0]    fx_we    = '0;
    logic [NREQ*AW-1:0] fx_addr  = '0;
    logic [NREQ*DW-1:0] fx_wdata = '0;
    logic [NREQ-1:0]    fx_gnt, fx_ack;
    logic [DW-1:0]      fx_rdata, fx_mem_wdata, fx_mem_rdata;
    logic [AW-1:0]      fx_mem_addr;
    logic               fx_mem_we, fx_busy;
    arb_state_t         fx_dbg_state;

    mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .PRIO_FIXED(0)) u_rr (
        .clk(clk), .init(init), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .PRIO_FIXED(1)) u_fx (
        .clk(clk), .init(init), .req(fx_req), .we(fx_we), .addr(fx_addr), .wdata(fx_wdata),
        .gnt(fx_gnt), .ack(fx_ack), .rdata(fx_rdata), .mem_addr(fx_mem_addr),
        .mem_wdata(fx_mem_wdata), .mem_we(fx_mem_we), .mem_rdata(fx_mem_rdata),
        .busy(fx_busy), .dbg_state(fx_dbg_state)
    );

    // synchronous memory: write and read both at the end of the address cycle
    logic [DW-1:0] mem [0:255];
    logic          ld_en   = 1'b0;
    logic [7:0]    ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    assign fx_mem_rdata = fx_mem_addr ^ 16'h5A5A;

    // scoreboard
    logic [DW-1:0]   exp_q[$];
    logic [NREQ-1:0] exp_ack_q[$];
    int total = 0;
    int bad   = 0;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic load_word(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        init = 1'b1; req = '0; we = '0; fx_req = '0; fx_we = '0;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic wait_ack(input bit use_fx, output logic [NREQ-1:0] a, output bit timeout);
        timeout = 1'b1;
        a = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((use_fx ? fx_ack : ack) != '0) begin
                a = use_fx ? fx_ack : ack;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 init = 1'b1;
        #1;
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt actual=%b required=000", gnt); end
        total++; if (ack !== 3'b000) begin bad++; $display("FAIL reset_ack actual=%b required=000", ack); end
        total++; if (rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata actual=%h required=0000", rdata); end
        total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_mem_addr actual=%h required=0000", mem_addr); end
        total++; if (mem_wdata !== 16'h0) begin bad++; $display("FAIL reset_mem_wdata actual=%h required=0000", mem_wdata); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we actual=%b required=0", mem_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy actual=%b required=0", busy); end
        total++; if (dbg_state !== ARB_IDLE) begin bad++; $display("FAIL reset_state actual=%0d required=%0d", dbg_state, ARB_IDLE); end
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic test_single_read();
        logic [DW-1:0] e;
        load_word(8'h40, 16'hBEEF);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0*AW +: AW] = 16'h0040;
        exp_q.push_back(16'hBEEF);
        @(negedge clk);
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL read_gnt_addr actual=%b required=001", gnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy actual=%b required=1", busy); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL read_mem_we actual=%b required=0", mem_we); end
        total++; if (mem_addr !== 16'h0040) begin bad++; $display("FAIL read_mem_addr actual=%h required=0040", mem_addr); end
        total++; if (dbg_state !== ARB_ADDR) begin bad++; $display("FAIL read_state_addr actual=%0d required=%0d", dbg_state, ARB_ADDR); end
        @(negedge clk);
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL read_gnt_data actual=%b required=001", gnt); end
        total++; if (ack !== 3'b000) begin bad++; $display("FAIL read_early_ack actual=%b required=000", ack); end
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if (ack !== 3'b001) begin bad++; $display("FAIL read_ack actual=%b required=001", ack); end
        total++; if (rdata !== e) begin bad++; $display("FAIL read_rdata actual=%h required=%h", rdata, e); end
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL read_gnt_release actual=%b required=000", gnt); end
        req[0] = 1'b0;
        @(negedge clk);
        total++; if (ack !== 3'b000) begin bad++; $display("FAIL read_ack_width actual=%b required=000", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_idle actual=%b required=0", busy); end
    endtask

    task automatic test_single_write();
        logic [NREQ-1:0] a;
        bit              to;
        logic [DW-1:0]   e;
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1*AW +: AW] = 16'h0010; wdata[1*DW +: DW] = 16'h1234;
        @(negedge clk);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL write_mem_we actual=%b required=1", mem_we); end
        total++; if (mem_addr !== 16'h0010) begin bad++; $display("FAIL write_mem_addr actual=%h required=0010", mem_addr); end
        total++; if (mem_wdata !== 16'h1234) begin bad++; $display("FAIL write_mem_wdata actual=%h required=1234", mem_wdata); end
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL write_gnt actual=%b required=010", gnt); end
        @(negedge clk);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL write_we_drop actual=%b required=0", mem_we); end
        @(negedge clk);
        total++; if (ack !== 3'b010) begin bad++; $display("FAIL write_ack actual=%b required=010", ack); end
        req[1] = 1'b0; we[1] = 1'b0;
        // read back through requester 0
        @(negedge clk);
        req[0] = 1'b1; addr[0*AW +: AW] = 16'h0010;
        exp_q.push_back(16'h1234);
        wait_ack(1'b0, a, to);
        req[0] = 1'b0;
        e = exp_q.pop_front();
        total++; if (to || a !== 3'b001) begin bad++; $display("FAIL readback_ack actual=%b timeout=%0d required=001", a, to); end
        total++; if (rdata !== e) begin bad++; $display("FAIL readback_rdata actual=%h required=%h", rdata, e); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] a, ea;
        logic [DW-1:0]   e;
        bit              to;
        logic [DW-1:0]   vals [3];
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            vals[i] = 16'(16'hA000 + i * 16'h0111 + $urandom_range(0, 15) * 16'h1000);
            load_word(8'(8'h20 + i), vals[i]);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) addr[i*AW +: AW] = 16'(16'h0020 + i);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_ack_q.push_back(NREQ'(1) << (k % 3));
            exp_q.push_back(vals[k % 3]);
        end
        for (int k = 0; k < 6; k++) begin
            wait_ack(1'b0, a, to);
            if (k == 5) req = '0;
            ea = exp_ack_q.pop_front();
            e  = exp_q.pop_front();
            total++; if (to || a !== ea) begin bad++; $display("FAIL rr_order[%0d] actual=%b timeout=%0d required=%b", k, a, to, ea); end
            total++; if (rdata !== e) begin bad++; $display("FAIL rr_rdata[%0d] actual=%h required=%h", k, rdata, e); end
            total++; if (!$onehot(a)) begin bad++; $display("FAIL rr_onehot[%0d] actual=%b required=onehot", k, a); end
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle_after actual=%b required=0", busy); end
    endtask

    task automatic test_ack_masking();
        logic [NREQ-1:0] a, ea;
        logic [DW-1:0]   e;
        bit              to;
        pulse_reset();
        load_word(8'h30, 16'hC000);
        load_word(8'h32, 16'hC222);
        @(negedge clk);
        addr[0*AW +: AW] = 16'h0030; addr[2*AW +: AW] = 16'h0032;
        req = 3'b101;
        exp_ack_q.push_back(3'b001); exp_q.push_back(16'hC000);
        exp_ack_q.push_back(3'b100); exp_q.push_back(16'hC222);
        exp_ack_q.push_back(3'b001); exp_q.push_back(16'hC000);
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b0, a, to);
            if (k == 2) req = 3'b001;
            ea = exp_ack_q.pop_front();
            e  = exp_q.pop_front();
            total++; if (to || a !== ea) begin bad++; $display("FAIL mask_order[%0d] actual=%b timeout=%0d required=%b", k, a, to, ea); end
            total++; if (rdata !== e) begin bad++; $display("FAIL mask_rdata[%0d] actual=%h required=%h", k, rdata, e); end
        end
        // requester 0 alone kept high: one idle cycle, then granted again
        exp_ack_q.push_back(3'b001); exp_q.push_back(16'hC000);
        @(negedge clk);
        total++; if (gnt !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL mask_gap actual=gnt %b busy %b required=gnt 000 busy 0", gnt, busy); end
        @(negedge clk);
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL mask_regrant actual=%b required=001", gnt); end
        req = '0;
        wait_ack(1'b0, a, to);
        ea = exp_ack_q.pop_front();
        e  = exp_q.pop_front();
        total++; if (to || a !== ea) begin bad++; $display("FAIL drop_req_ack actual=%b timeout=%0d required=%b", a, to, ea); end
        total++; if (rdata !== e) begin bad++; $display("FAIL drop_req_rdata actual=%h required=%h", rdata, e); end
    endtask

    task automatic test_reset_mid();
        int seen;
        pulse_reset();
        load_word(8'h50, 16'h7777);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1*AW +: AW] = 16'h0050; wdata[1*DW +: DW] = 16'hDEAD;
        @(negedge clk);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL mid_we_before actual=%b required=1", mem_we); end
        #1 init = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_we_async actual=%b required=0", mem_we); end
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL mid_gnt_async actual=%b required=000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_async actual=%b required=0", busy); end
        req = '0; we = '0;
        @(negedge clk);
        init = 1'b0;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (ack != '0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_ack actual=%0d required=0", seen); end
        total++; if (mem[8'h50] !== 16'h7777) begin bad++; $display("FAIL mid_no_write actual=%h required=7777", mem[8'h50]); end
        req = 3'b111;
        @(negedge clk);
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL mid_first_gnt actual=%b required=001", gnt); end
        req = '0;
        for (int n = 0; n < 10 && busy; n++) @(negedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_drain actual=%b required=0", busy); end
    endtask

    task automatic test_fixed_priority();
        logic [NREQ-1:0] ea;
        logic [DW-1:0]   e;
        int              got;
        bit              pulsed;
        for (int i = 0; i < 3; i++) fx_addr[i*AW +: AW] = 16'(16'h0100 + i);
        exp_ack_q.push_back(3'b010); exp_q.push_back(16'h0101 ^ 16'h5A5A);
        exp_ack_q.push_back(3'b001); exp_q.push_back(16'h0100 ^ 16'h5A5A);
        exp_ack_q.push_back(3'b010); exp_q.push_back(16'h0101 ^ 16'h5A5A);
        exp_ack_q.push_back(3'b100); exp_q.push_back(16'h0102 ^ 16'h5A5A);
        @(negedge clk);
        fx_req = 3'b110;
        got = 0;
        pulsed = 1'b0;
        for (int n = 0; n < 60 && got < 4; n++) begin
            @(negedge clk);
            if (fx_gnt[1] && !pulsed) begin fx_req[0] = 1'b1; pulsed = 1'b1; end
            if (fx_gnt[0]) fx_req[0] = 1'b0;
            if (fx_ack != '0) begin
                ea = exp_ack_q.pop_front();
                e  = exp_q.pop_front();
                total++; if (fx_ack !== ea) begin bad++; $display("FAIL fx_order[%0d] actual=%b required=%b", got, fx_ack, ea); end
                total++; if (fx_rdata !== e) begin bad++; $display("FAIL fx_rdata[%0d] actual=%h required=%h", got, fx_rdata, e); end
                got++;
            end
        end
        total++; if (got !== 4) begin bad++; $display("FAIL fx_ack_count actual=%0d required=4", got); end
        fx_req = '0;
        for (int n = 0; n < 10 && fx_busy; n++) @(negedge clk);
        @(negedge clk);
        total++; if (fx_busy !== 1'b0) begin bad++; $display("FAIL fx_drain actual=%b required=0", fx_busy); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_ack_masking();
        test_reset_mid();
        test_fixed_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
